// File: rtl/l1_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate one-word-line L1 cache; CPU-side responder with
// a valid/ready next-level port. Read hit answers the cycle after acceptance; misses and writes wait on memory.
module l1_cache_responder #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 32,
  parameter int LINES        = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESSWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic [DATAWIDTH-1:0]    resp_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0]    mem_wdata,
  input  logic                    mem_resp_valid,
  input  logic [DATAWIDTH-1:0]    mem_rdata,
  output logic                    hit_pulse,
  output logic                    miss_pulse
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = ADDRESSWIDTH - 2 - IDXW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LINES-1:0]        r_valid;
  logic [TAGW-1:0]         r_tag  [LINES];
  logic [DATAWIDTH-1:0]    r_data [LINES];
  logic [ADDRESSWIDTH-1:0] r_addr;
  logic [DATAWIDTH-1:0]    r_wdata;
  logic [DATAWIDTH-1:0]    r_rdata;
  logic                    r_hit;
  logic                    r_miss;

  logic                    w_accept;
  logic                    w_hit;
  logic                    w_fill;
  logic [IDXW-1:0]         w_req_idx;
  logic [TAGW-1:0]         w_req_tag;
  logic [IDXW-1:0]         w_cap_idx;
  logic [TAGW-1:0]         w_cap_tag;

  assign w_req_idx = req_addr[2 +: IDXW];
  assign w_req_tag = req_addr[ADDRESSWIDTH-1 -: TAGW];
  assign w_cap_idx = r_addr[2 +: IDXW];
  assign w_cap_tag = r_addr[ADDRESSWIDTH-1 -: TAGW];
  assign w_hit     = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_accept  = req_valid && req_ready;
  // Fill only from RD_WAIT: data arriving alongside the RD_REQ handshake is dropped.
  assign w_fill    = (r_state == S_RD_WAIT) && mem_resp_valid;

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (req_write)  w_next = S_WR_REQ;
          else if (w_hit) w_next = S_RESP;
          else            w_next = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_resp_valid) w_next = S_RESP;
      end
      S_WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        if (mem_req_ready) w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_hit   <= w_hit;
        r_miss  <= !w_hit;
        if (req_write)  r_rdata <= '0;
        else if (w_hit) r_rdata <= r_data[w_req_idx];
      end
      if (w_fill) begin
        r_valid[w_cap_idx] <= 1'b1;
        r_rdata            <= mem_rdata;
      end
    end
  end

  // Tag/data storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_accept && req_write && w_hit) r_data[w_req_idx] <= req_wdata;
      if (w_fill) begin
        r_tag[w_cap_idx]  <= w_cap_tag;
        r_data[w_cap_idx] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_l1_cache_responder.sv
// Directed bench for l1_cache_responder with a response scoreboard and a reactive next-level model.
module tb_l1_cache_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        hit_pulse;
  logic        miss_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        hit;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  l1_cache_responder #(.DATAWIDTH(32), .ADDRESSWIDTH(32), .LINES(256)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; the bench plays the next level, stalling ready for rdy_delay cycles.
  task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_hit, input logic [31:0] mem_rd, input int rdy_delay,
                        input logic junk, input logic [31:0] exp_rdata);
    exp_t e;
    int   n;
    int   nreq;
    logic hs;
    logic given;
    logic done;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("req_ready_before_issue", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    e.hit   = exp_hit;
    e.rdata = exp_rdata;
    sb.push_back(e);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
    nreq  = 0;
    hs    = 1'b0;
    given = 1'b0;
    done  = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clock);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (cyc == 1) begin
        chk("hit_pulse", hit_pulse, exp_hit);
        chk("miss_pulse", miss_pulse, !exp_hit);
      end else begin
        chk("no_extra_pulse", {hit_pulse, miss_pulse}, 0);
      end
      if (resp_valid) begin
        done = 1'b1;
        chk("sb_has_entry", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          if (!wr && e.hit) chk("read_hit_latency", cyc, 1);
        end
      end else if (mem_req_valid) begin
        chk("mem_req_write", mem_req_write, wr);
        chk("mem_addr", mem_addr, addr);
        if (wr) chk("mem_wdata", mem_wdata, wdata);
        chk("req_ready_busy", req_ready, 0);
        nreq++;
        if (nreq > rdy_delay) begin
          mem_req_ready = 1'b1;
          hs = 1'b1;
          if (junk) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'hBAD0_BAD0;
          end
        end
      end else if (hs && !wr && !given) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = mem_rd;
        given          = 1'b1;
      end
    end
    chk("resp_seen", done, 1);
    chk("mem_req_issued", hs, !(exp_hit && !wr));
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge clock);
    chk("resp_one_cycle", resp_valid, 0);
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_write", mem_req_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
    reset = 1'b0;
    @(negedge clock);

    // Miss fill then hit; write hit updates the line and still goes to memory.
    cpu_op(0, 32'h0000_0100, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
    cpu_op(0, 32'h0000_0100, 0, 1, 0, 0, 0, 32'hDEAD_BEEF);
    cpu_op(1, 32'h0000_0100, 32'h1234_5678, 1, 0, 0, 0, 32'h0);
    cpu_op(0, 32'h0000_0100, 0, 1, 0, 0, 0, 32'h1234_5678);
    // Write miss does not allocate.
    cpu_op(1, 32'h0000_0200, 32'hA0A0_A0A0, 0, 0, 1, 0, 32'h0);
    cpu_op(0, 32'h0000_0200, 0, 0, 32'h0000_0200, 0, 0, 32'h0000_0200);
    // 0x500 shares index 0x40 with 0x100 and evicts it.
    cpu_op(0, 32'h0000_0500, 0, 0, 32'h5555_0500, 0, 0, 32'h5555_0500);
    cpu_op(0, 32'h0000_0100, 0, 0, 32'h1111_0100, 2, 0, 32'h1111_0100);
    // Top index with a 5-cycle ready stall, then bottom index; neither disturbs the other.
    cpu_op(1, 32'h0000_03FC, 32'hA5A5_A5A5, 0, 0, 5, 0, 32'h0);
    cpu_op(0, 32'h0000_03FC, 0, 0, 32'h0FF0_0FF0, 5, 0, 32'h0FF0_0FF0);
    cpu_op(0, 32'h0000_0000, 0, 0, 32'h0000_AAAA, 0, 0, 32'h0000_AAAA);
    cpu_op(0, 32'h0000_03FC, 0, 1, 0, 0, 0, 32'h0FF0_0FF0);
    cpu_op(0, 32'h0000_0000, 0, 1, 0, 0, 0, 32'h0000_AAAA);
    // Data presented with the RD_REQ handshake must be ignored.
    cpu_op(0, 32'h0000_0600, 0, 0, 32'h6666_6666, 1, 1, 32'h6666_6666);

    // Stray memory response while idle.
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hEEEE_EEEE;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    chk("stray_no_resp", resp_valid, 0);
    cpu_op(0, 32'h0000_0600, 0, 1, 0, 0, 0, 32'h6666_6666);

    // Reset while waiting on read data.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0300;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("rm_mem_req_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    chk("rm_in_rd_wait", mem_req_valid, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rm_post_rst_mem_req_valid", mem_req_valid, 0);
    chk("rm_post_rst_req_ready", req_ready, 1);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBADD_CAFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_resp_valid = 1'b0;
      chk("rm_no_resp", resp_valid, 0);
    end
    cpu_op(0, 32'h0000_0300, 0, 0, 32'h3333_0300, 0, 0, 32'h3333_0300);
    cpu_op(0, 32'h0000_0600, 0, 0, 32'h7777_0600, 0, 0, 32'h7777_0600);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
